axi_redirect_cfg_ctrl: RTL and testbench



---
 rtl/axi_redirect_pkg.sv | 20 ++
 rtl/axi_redirect_drain_timer.sv | 41 ++++
 rtl/axi_redirect_cfg_ctrl.sv | 135 +++++++++++++
 tb/tb_axi_redirect_cfg_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_redirect_pkg.sv
// Shared types and constants for the redirect configuration controller.
//   redir_state_e : sequencing states of the config controller
//   ST_*          : completion status codes reported with cfg_done_o
package axi_redirect_pkg;

    localparam int unsigned STATUS_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLOCK  = 3'd1,
        DRAIN  = 3'd2,
        APPLY  = 3'd3,
        RESUME = 3'd4
    } redir_state_e;

    localparam logic [STATUS_W-1:0] ST_OK      = 2'b00;
    localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b01;
    localparam logic [STATUS_W-1:0] ST_INVALID = 2'b10;

endpackage

// File: rtl/axi_redirect_drain_timer.sv
// Saturating drain-cycle counter with a terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to zero (wins over enable)
//   enable     : count one cycle
//   expired_c  : count has reached DRAIN_TIMEOUT-1 (never set when DRAIN_TIMEOUT==0)
module axi_redirect_drain_timer #(
    parameter int unsigned TIMEOUT_W     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] count;

    // Counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // A zero timeout disables expiry entirely.
    generate
        if (DRAIN_TIMEOUT == 0) begin : g_no_timeout
            assign expired_c = 1'b0;
        end else begin : g_timeout
            assign expired_c = (count == TIMEOUT_W'(DRAIN_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/axi_redirect_cfg_ctrl.sv
// Sequences safe updates of the redirect mapping used by one slave port's
// AW/AR decoders: accept request, stall new addresses, drain outstanding
// traffic, apply the mapping atomically, release the stall, report status.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_valid_i/ready : config request handshake (ready decoded from IDLE)
//   cfg_enable_i      : 1 install redirect, 0 clear redirect
//   cfg_source_i/target_i : redirect source / target port indices
//   cfg_done_o/status : one-cycle completion pulse and its status
//   aw/ar_outstanding_i, aw_error_busy_i : drain conditions
//   stall_o           : gate to the decoders' grant inputs
//   source_r/target_r/redirect_valid_r : applied mapping
module axi_redirect_cfg_ctrl
    import axi_redirect_pkg::*;
#(
    parameter int unsigned N_INIT_PORT   = 8,
    parameter int unsigned LOG_N_INIT    = 3,
    parameter int unsigned TIMEOUT_W     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic                  cfg_enable_i,
    input  logic [LOG_N_INIT-1:0] cfg_source_i,
    input  logic [LOG_N_INIT-1:0] cfg_target_i,
    output logic                  cfg_done_o,
    output logic [STATUS_W-1:0]   cfg_status_o,
    input  logic                  aw_outstanding_i,
    input  logic                  ar_outstanding_i,
    input  logic                  aw_error_busy_i,
    output logic                  stall_o,
    output logic [LOG_N_INIT-1:0] source_r,
    output logic [LOG_N_INIT-1:0] target_r,
    output logic                  redirect_valid_r
);

    redir_state_e          state;
    logic                  pend_enable;
    logic [LOG_N_INIT-1:0] pend_source;
    logic [LOG_N_INIT-1:0] pend_target;

    logic req_invalid_c;
    logic drained_c;
    logic expired_c;

    assign cfg_ready_o = (state == IDLE);

    // Indices are widened before the range check so narrow index widths
    // still compare correctly against N_INIT_PORT.
    assign req_invalid_c = cfg_enable_i &&
                           ((32'(cfg_source_i) >= N_INIT_PORT) ||
                            (32'(cfg_target_i) >= N_INIT_PORT) ||
                            (cfg_source_i == cfg_target_i));

    assign drained_c = ~aw_outstanding_i & ~ar_outstanding_i & ~aw_error_busy_i;

    axi_redirect_drain_timer #(
        .TIMEOUT_W     (TIMEOUT_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == RESUME),
        .enable    (state == DRAIN),
        .expired_c (expired_c)
    );

    // Sequencer with registered stall/done/status/mapping outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pend_enable      <= 1'b0;
            pend_source      <= '0;
            pend_target      <= '0;
            stall_o          <= 1'b0;
            cfg_done_o       <= 1'b0;
            cfg_status_o     <= ST_OK;
            source_r         <= '0;
            target_r         <= '0;
            redirect_valid_r <= 1'b0;
        end else begin
            cfg_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        pend_enable <= cfg_enable_i;
                        pend_source <= cfg_source_i;
                        pend_target <= cfg_target_i;
                        if (req_invalid_c) begin
                            // Rejected requests never stall the decoders.
                            state        <= RESUME;
                            cfg_done_o   <= 1'b1;
                            cfg_status_o <= ST_INVALID;
                        end else begin
                            state   <= BLOCK;
                            stall_o <= 1'b1;
                        end
                    end
                end
                // Extra cycle so a decoder handshake made in the accept cycle
                // is visible in the outstanding flags before draining.
                BLOCK: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (drained_c) begin
                        state <= APPLY;
                    end else if (expired_c) begin
                        state        <= RESUME;
                        cfg_done_o   <= 1'b1;
                        cfg_status_o <= ST_TIMEOUT;
                    end
                end
                APPLY: begin
                    source_r         <= pend_source;
                    target_r         <= pend_target;
                    redirect_valid_r <= pend_enable;
                    state            <= RESUME;
                    cfg_done_o       <= 1'b1;
                    cfg_status_o     <= ST_OK;
                end
                RESUME: begin
                    stall_o <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    stall_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_redirect_cfg_ctrl.sv
// Self-checking bench for axi_redirect_cfg_ctrl. Each request is predicted at
// transaction level (done cycle, status, resulting mapping) and every cycle
// of the sequence is compared against that prediction.
module tb_axi_redirect_cfg_ctrl;

    localparam int unsigned N_INIT_PORT   = 8;
    localparam int unsigned LOG_N_INIT    = 3;
    localparam int unsigned TIMEOUT_W     = 16;
    localparam int unsigned DRAIN_TIMEOUT = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic                  cfg_enable_i;
    logic [LOG_N_INIT-1:0] cfg_source_i;
    logic [LOG_N_INIT-1:0] cfg_target_i;
    logic                  cfg_done_o;
    logic [1:0]            cfg_status_o;
    logic                  aw_outstanding_i;
    logic                  ar_outstanding_i;
    logic                  aw_error_busy_i;
    logic                  stall_o;
    logic [LOG_N_INIT-1:0] source_r;
    logic [LOG_N_INIT-1:0] target_r;
    logic                  redirect_valid_r;

    int total;
    int bad;

    // Reference mapping state.
    logic [LOG_N_INIT-1:0] m_src;
    logic [LOG_N_INIT-1:0] m_tgt;
    logic                  m_valid;
    logic [1:0]            m_status;

    axi_redirect_cfg_ctrl #(
        .N_INIT_PORT   (N_INIT_PORT),
        .LOG_N_INIT    (LOG_N_INIT),
        .TIMEOUT_W     (TIMEOUT_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_source_i     (cfg_source_i),
        .cfg_target_i     (cfg_target_i),
        .cfg_done_o       (cfg_done_o),
        .cfg_status_o     (cfg_status_o),
        .aw_outstanding_i (aw_outstanding_i),
        .ar_outstanding_i (ar_outstanding_i),
        .aw_error_busy_i  (aw_error_busy_i),
        .stall_o          (stall_o),
        .source_r         (source_r),
        .target_r         (target_r),
        .redirect_valid_r (redirect_valid_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Busy profile: the selected drain signal is high in cycles T+n with n < busy_len.
    task automatic drive_busy(input int kind, input int n, input int busy_len);
        logic b;
        b = (n < busy_len);
        aw_outstanding_i = (kind == 0) ? b : 1'b0;
        ar_outstanding_i = (kind == 1) ? b : 1'b0;
        aw_error_busy_i  = (kind == 2) ? b : 1'b0;
    endtask

    // Transaction-level prediction: cycle offset of done and its status.
    function automatic void predict(input logic en, input logic [LOG_N_INIT-1:0] src,
                                    input logic [LOG_N_INIT-1:0] tgt, input int busy_len,
                                    output int done_n, output logic [1:0] st);
        int k;
        if (en && ((int'(src) >= int'(N_INIT_PORT)) || (int'(tgt) >= int'(N_INIT_PORT)) || src == tgt)) begin
            done_n = 1;
            st     = 2'b10;
        end else begin
            // Draining is observed no earlier than two cycles after acceptance.
            k = (busy_len > 2) ? busy_len : 2;
            if (k - 2 < int'(DRAIN_TIMEOUT)) begin
                done_n = k + 2;
                st     = 2'b00;
            end else begin
                done_n = int'(DRAIN_TIMEOUT) + 2;
                st     = 2'b01;
            end
        end
    endfunction

    // Issue one request at the current sample point (cycle T) and check
    // every cycle up to the first IDLE cycle after done.
    task automatic run_req(input logic en, input logic [LOG_N_INIT-1:0] src,
                           input logic [LOG_N_INIT-1:0] tgt, input int busy_len, input int kind);
        int         done_n;
        logic [1:0] st;
        logic       stall_path;
        predict(en, src, tgt, busy_len, done_n, st);
        stall_path = (st != 2'b10);
        check_eq("ready_at_T", 32'(cfg_ready_o), 32'd1);
        cfg_valid_i  = 1'b1;
        cfg_enable_i = en;
        cfg_source_i = src;
        cfg_target_i = tgt;
        drive_busy(kind, 0, busy_len);
        for (int n = 1; n <= done_n + 1; n++) begin
            @(posedge clk);
            #1;
            cfg_valid_i  = 1'b0;
            cfg_enable_i = 1'($urandom);
            cfg_source_i = LOG_N_INIT'($urandom);
            cfg_target_i = LOG_N_INIT'($urandom);
            if (n == done_n && st == 2'b00) begin
                m_src   = src;
                m_tgt   = tgt;
                m_valid = en;
            end
            if (n == done_n) m_status = st;
            check_eq("stall", 32'(stall_o), 32'(stall_path && n <= done_n));
            check_eq("done", 32'(cfg_done_o), 32'(n == done_n));
            check_eq("ready", 32'(cfg_ready_o), 32'(n > done_n));
            check_eq("map_src", 32'(source_r), 32'(m_src));
            check_eq("map_tgt", 32'(target_r), 32'(m_tgt));
            check_eq("map_valid", 32'(redirect_valid_r), 32'(m_valid));
            if (n >= done_n) check_eq("status", 32'(cfg_status_o), 32'(m_status));
            drive_busy(kind, n, busy_len);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
        check_eq({tag, "_src"}, 32'(source_r), 32'd0);
        check_eq({tag, "_tgt"}, 32'(target_r), 32'd0);
        check_eq({tag, "_valid"}, 32'(redirect_valid_r), 32'd0);
        check_eq({tag, "_done"}, 32'(cfg_done_o), 32'd0);
        check_eq({tag, "_status"}, 32'(cfg_status_o), 32'd0);
        check_eq({tag, "_ready"}, 32'(cfg_ready_o), 32'd1);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        cfg_valid_i      = 1'b0;
        cfg_enable_i     = 1'b0;
        cfg_source_i     = '0;
        cfg_target_i     = '0;
        aw_outstanding_i = 1'b0;
        ar_outstanding_i = 1'b0;
        aw_error_busy_i  = 1'b0;
        m_src            = '0;
        m_tgt            = '0;
        m_valid          = 1'b0;
        m_status         = 2'b00;

        #2;
        check_reset_values("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Minimum-latency install, drain hold on AR, drain timeout on AW.
        run_req(1'b1, 3'd2, 3'd5, 0, 0);
        run_req(1'b1, 3'd2, 3'd5, 12, 1);
        run_req(1'b1, 3'd6, 3'd1, 40, 0);
        // Drain boundary: drained on the last allowed count vs one later.
        run_req(1'b1, 3'd7, 3'd0, 17, 2);
        run_req(1'b1, 3'd1, 3'd4, 18, 2);
        // Rejected requests, back to back.
        run_req(1'b1, 3'd3, 3'd3, 0, 0);
        run_req(1'b1, 3'd4, 3'd4, 5, 1);
        // Install then clear.
        run_req(1'b1, 3'd2, 3'd5, 0, 0);
        run_req(1'b0, 3'd2, 3'd5, 3, 1);
        // Clear with equal indices is not validated.
        run_req(1'b0, 3'd6, 3'd6, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic en;
            int   blen;
            en   = ($urandom_range(0, 3) != 0);
            blen = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 22));
            run_req(en, LOG_N_INIT'($urandom), LOG_N_INIT'($urandom), blen, int'($urandom_range(0, 2)));
        end

        // Install something, then reset in the middle of a drain.
        run_req(1'b1, 3'd3, 3'd6, 0, 0);
        cfg_valid_i      = 1'b1;
        cfg_enable_i     = 1'b1;
        cfg_source_i     = 3'd1;
        cfg_target_i     = 3'd2;
        ar_outstanding_i = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            cfg_valid_i = 1'b0;
        end
        check_eq("pre_rst_stall", 32'(stall_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        ar_outstanding_i = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_src   = '0;
        m_tgt   = '0;
        m_valid = 1'b0;
        m_status = 2'b00;
        @(posedge clk);
        #1;
        run_req(1'b1, 3'd0, 3'd7, 4, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
